// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encodings, bus-level constants and the
// synchronized bus event bundle passed from the front end to the target FSM.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT
  } i2c_state_e;

  localparam logic ACK   = 1'b0;
  localparam logic NACK  = 1'b1;
  localparam logic WRITE = 1'b0;
  localparam logic READ  = 1'b1;

  localparam logic [6:0] I2C_DEV_ADDR = 7'h50;

  typedef struct packed {
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic sda;
  } bus_evt_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and turns them into registered
// single-cycle events: SCL edges, START, STOP, plus the synchronized SDA level.
module i2c_bus_sync import i2c_pkg::*; (
  input  logic     clk,
  input  logic     reset,
  input  logic     scl,
  input  logic     sda,
  output bus_evt_t evt
);

  logic [1:0] scl_sync, sda_sync;
  logic       scl_q, sda_q;
  bus_evt_t   evt_n;

  always_comb begin
    evt_n.scl_rise = scl_sync[1] & ~scl_q;
    evt_n.scl_fall = ~scl_sync[1] & scl_q;
    // SDA may only move while SCL is high for START/STOP
    evt_n.start    = scl_sync[1] & scl_q & sda_q & ~sda_sync[1];
    evt_n.stop     = scl_sync[1] & scl_q & ~sda_q & sda_sync[1];
    evt_n.sda      = sda_sync[1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      evt      <= '{scl_rise: 1'b0, scl_fall: 1'b0, start: 1'b0, stop: 1'b0, sda: 1'b1};
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
      evt      <= evt_n;
    end
  end

endmodule

// File: rtl/i2c_slave.sv
// EEPROM-style I2C target: address match, ACK generation, auto-incrementing
// byte pointer and a simple write-strobe / combinational-read memory port.
module i2c_slave import i2c_pkg::*; #(
  parameter logic [6:0] DEV_ADDR = I2C_DEV_ADDR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda_w,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  output logic       busy
);

  bus_evt_t   evt;
  i2c_state_e state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n, ptr, ptr_n, wdata_n, rx_byte;
  logic       rw, rw_n, ptr_loaded, ptr_loaded_n, acked, acked_n;
  logic       sda_oe, sda_oe_n, busy_n, we_n, rd_load, rd_load_n;

  i2c_bus_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .scl   (scl),
    .sda   (sda_w),
    .evt   (evt)
  );

  assign sda_w    = sda_oe ? 1'b0 : 1'bz;
  assign mem_addr = ptr;
  assign rx_byte  = {shreg[6:0], evt.sda};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd7;
      shreg      <= '0;
      ptr        <= '0;
      mem_wdata  <= '0;
      rw         <= WRITE;
      ptr_loaded <= 1'b0;
      acked      <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      mem_we     <= 1'b0;
      rd_load    <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      ptr        <= ptr_n;
      mem_wdata  <= wdata_n;
      rw         <= rw_n;
      ptr_loaded <= ptr_loaded_n;
      acked      <= acked_n;
      sda_oe     <= sda_oe_n;
      busy       <= busy_n;
      mem_we     <= we_n;
      rd_load    <= rd_load_n;
    end
  end

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shreg_n      = shreg;
    ptr_n        = ptr;
    wdata_n      = mem_wdata;
    rw_n         = rw;
    ptr_loaded_n = ptr_loaded;
    acked_n      = acked;
    sda_oe_n     = sda_oe;
    busy_n       = busy;
    we_n         = 1'b0;
    rd_load_n    = 1'b0;

    // pointer moves one clk after a write strobe or a read load
    if (mem_we || rd_load) ptr_n = ptr + 8'd1;

    if (evt.stop) begin
      state_n  = ST_IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (evt.start) begin
      state_n   = ST_ADDR;
      bit_cnt_n = 3'd7;
      sda_oe_n  = 1'b0;
      acked_n   = 1'b0;
    end else begin
      case (state)
        ST_ADDR: if (evt.scl_rise) begin
          shreg_n   = rx_byte;
          bit_cnt_n = bit_cnt - 3'd1;
          if (bit_cnt == 3'd0) begin
            rw_n = evt.sda;
            if (shreg[6:0] == DEV_ADDR) begin
              state_n = ST_ADDR_ACK;
              busy_n  = 1'b1;
            end else begin
              state_n = ST_WAIT;
              busy_n  = 1'b0;
            end
          end
        end

        // sda_oe doubles as the "ACK already on the bus" phase flag
        ST_ADDR_ACK: if (evt.scl_fall) begin
          if (!sda_oe) begin
            sda_oe_n = 1'b1;
          end else begin
            bit_cnt_n = 3'd7;
            if (rw == WRITE) begin
              state_n      = ST_WR_DATA;
              ptr_loaded_n = 1'b0;
              sda_oe_n     = 1'b0;
            end else begin
              state_n   = ST_RD_DATA;
              shreg_n   = {mem_rdata[6:0], 1'b0};
              sda_oe_n  = ~mem_rdata[7];
              rd_load_n = 1'b1;
            end
          end
        end

        ST_WR_DATA: if (evt.scl_rise) begin
          shreg_n   = rx_byte;
          bit_cnt_n = bit_cnt - 3'd1;
          if (bit_cnt == 3'd0) begin
            state_n = ST_WR_ACK;
            if (ptr_loaded) begin
              we_n    = 1'b1;
              wdata_n = rx_byte;
            end else begin
              ptr_n        = rx_byte;
              ptr_loaded_n = 1'b1;
            end
          end
        end

        ST_WR_ACK: if (evt.scl_fall) begin
          if (!sda_oe) begin
            sda_oe_n = 1'b1;
          end else begin
            sda_oe_n  = 1'b0;
            state_n   = ST_WR_DATA;
            bit_cnt_n = 3'd7;
          end
        end

        ST_RD_DATA: begin
          if (evt.scl_fall) begin
            sda_oe_n = ~shreg[7];
            shreg_n  = {shreg[6:0], 1'b0};
          end
          if (evt.scl_rise) begin
            bit_cnt_n = bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) state_n = ST_RD_ACK;
          end
        end

        // first fall releases SDA, rise samples the master, second fall reloads
        ST_RD_ACK: begin
          if (evt.scl_rise) begin
            if (evt.sda == NACK) begin
              state_n  = ST_WAIT;
              sda_oe_n = 1'b0;
            end else begin
              acked_n = 1'b1;
            end
          end
          if (evt.scl_fall) begin
            if (acked) begin
              acked_n   = 1'b0;
              state_n   = ST_RD_DATA;
              bit_cnt_n = 3'd7;
              shreg_n   = {mem_rdata[6:0], 1'b0};
              sda_oe_n  = ~mem_rdata[7];
              rd_load_n = 1'b1;
            end else begin
              sda_oe_n = 1'b0;
            end
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bus-master bench for i2c_slave: directed transfers plus random transactions,
// checked against a transaction-level EEPROM model (pointer, memory, write queue).
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int Q = 4;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  wire        sda_w;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we, busy;

  logic [7:0] env_mem [256];
  logic       tb_wr = 1'b0;
  logic [7:0] tb_wa = '0, tb_wd = '0;

  // behavioural model state
  logic [7:0]  mmem [256];
  logic [7:0]  mptr = '0;
  logic        mloaded = 1'b0;
  logic        maddressed = 1'b0;
  logic [15:0] wq [$];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign sda_w = sda_m ? 1'bz : 1'b0;
  pullup (sda_w);
  assign mem_rdata = env_mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) env_mem[mem_addr] <= mem_wdata;
    else if (tb_wr) env_mem[tb_wa] <= tb_wd;
  end

  i2c_slave #(.DEV_ADDR(7'h50)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda_w     (sda_w),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // every write strobe must match the next write the model predicted
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (reset && mem_we) begin
        if (wq.size() == 0) chk("unexpected_we", 32'(mem_we), 32'd0);
        else begin
          e = wq.pop_front();
          chk("we_addr", 32'(mem_addr), 32'(e[15:8]));
          chk("we_data", 32'(mem_wdata), 32'(e[7:0]));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, required end of test");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_wa = a; tb_wd = d; tb_wr = 1'b1;
    wait_clk(1);
    tb_wr = 1'b0;
    mmem[a] = d;
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_m = b;  wait_clk(Q);
    scl = 1'b1; wait_clk(Q);
    s = sda_w;  wait_clk(Q);
    scl = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl = 1'b0;   wait_clk(Q);
    maddressed = 1'b0;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    sda_m = 1'b1; wait_clk(3*Q);
    maddressed = 1'b0;
    chk("busy_stop", 32'(busy), 32'd0);
    chk("sda_idle", 32'(sda_w), 32'd1);
    chk("ptr", 32'(mem_addr), 32'(mptr));
  endtask

  task automatic send_addr(input logic [6:0] a, input logic rwb);
    logic [7:0] bv;
    logic s;
    bv = {a, rwb};
    for (int i = 7; i >= 0; i--) clock_bit(bv[i], s);
    maddressed = (a == 7'h50);
    if (maddressed && rwb == WRITE) mloaded = 1'b0;
    clock_bit(1'b1, s);
    chk("addr_ack", 32'(s), maddressed ? 32'(ACK) : 32'(NACK));
    chk("busy_addr", 32'(busy), 32'(maddressed));
  endtask

  task automatic wr_byte(input logic [7:0] b);
    logic s;
    if (maddressed) begin
      if (!mloaded) begin
        mptr = b;
        mloaded = 1'b1;
      end else begin
        wq.push_back({mptr, b});
        mmem[mptr] = b;
        mptr = mptr + 8'd1;
      end
    end
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    chk("wr_ack", 32'(s), maddressed ? 32'(ACK) : 32'(NACK));
  endtask

  task automatic rd_byte(input logic ack_bit, output logic [7:0] got);
    logic s;
    logic [7:0] exp;
    exp = mmem[mptr];
    mptr = mptr + 8'd1;
    got = '0;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      got[i] = s;
    end
    clock_bit(ack_bit, s);
    chk("rd_data", 32'(got), 32'(exp));
  endtask

  initial begin
    logic [7:0] got;
    logic [6:0] a;
    logic       rwb, s;
    int         kind, n;

    #1 reset = 1'b0;
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
    poke(8'h20, 8'hC3);
    poke(8'h21, 8'h3C);
    poke(8'h30, 8'h35);
    chk("rst_sda", 32'(sda_w), 32'd1);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    wait_clk(4);

    // pointer write then two data bytes
    bus_start(); send_addr(7'h50, WRITE);
    wr_byte(8'h10); wr_byte(8'hA5); wr_byte(8'h5A);
    bus_stop();
    chk("wr_final_ptr", 32'(mem_addr), 32'h12);
    chk("wr_mem10", 32'(env_mem[8'h10]), 32'hA5);
    chk("wr_mem11", 32'(env_mem[8'h11]), 32'h5A);

    // random read through repeated START
    bus_start(); send_addr(7'h50, WRITE); wr_byte(8'h20);
    bus_start(); send_addr(7'h50, READ);
    rd_byte(ACK, got);  chk("rd_c3", 32'(got), 32'hC3);
    rd_byte(NACK, got); chk("rd_3c", 32'(got), 32'h3C);
    chk("rd_nack_release", 32'(sda_w), 32'd1);
    bus_stop();

    // foreign address is ignored
    bus_start(); send_addr(7'h51, WRITE); wr_byte(8'h99);
    bus_stop();

    // pointer wrap
    bus_start(); send_addr(7'h50, WRITE);
    wr_byte(8'hFF); wr_byte(8'h11); wr_byte(8'h22);
    bus_stop();
    chk("wrap_memff", 32'(env_mem[8'hFF]), 32'h11);
    chk("wrap_mem00", 32'(env_mem[8'h00]), 32'h22);
    chk("wrap_ptr", 32'(mem_addr), 32'h01);

    // STOP in the middle of a data byte, then a normal transfer
    bus_start(); send_addr(7'h50, WRITE); wr_byte(8'h40);
    clock_bit(1'b1, s); clock_bit(1'b0, s); clock_bit(1'b1, s); clock_bit(1'b1, s);
    bus_stop();
    bus_start(); send_addr(7'h50, WRITE); wr_byte(8'h41); wr_byte(8'h77);
    bus_stop();
    chk("after_abort_mem41", 32'(env_mem[8'h41]), 32'h77);

    // asynchronous reset while the target pulls SDA low during a read
    bus_start(); send_addr(7'h50, WRITE); wr_byte(8'h30);
    bus_start(); send_addr(7'h50, READ);
    chk("rd_drive_low", 32'(sda_w), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_sda", 32'(sda_w), 32'd1);
    chk("async_rst_addr", 32'(mem_addr), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_we", 32'(mem_we), 32'd0);
    chk("async_rst_wdata", 32'(mem_wdata), 32'd0);
    wait_clk(2);
    reset = 1'b1;
    mptr = '0; mloaded = 1'b0; maddressed = 1'b0;
    wait_clk(2);
    bus_stop();

    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          bus_start(); send_addr(7'h50, WRITE);
          n = $urandom_range(0, 3);
          wr_byte(8'($urandom));
          for (int k = 0; k < n; k++) wr_byte(8'($urandom));
          bus_stop();
        end
        1: begin
          bus_start(); send_addr(7'h50, WRITE); wr_byte(8'($urandom));
          bus_start(); send_addr(7'h50, READ);
          n = $urandom_range(1, 3);
          for (int k = 0; k < n; k++) rd_byte((k == n-1) ? NACK : ACK, got);
          bus_stop();
        end
        2: begin
          bus_start(); send_addr(7'h50, READ);
          n = $urandom_range(1, 2);
          for (int k = 0; k < n; k++) rd_byte((k == n-1) ? NACK : ACK, got);
          bus_stop();
        end
        default: begin
          a = 7'($urandom);
          if (a == 7'h50) a = 7'h51;
          rwb = 1'($urandom_range(0, 1));
          bus_start(); send_addr(a, rwb);
          if (rwb == WRITE) wr_byte(8'($urandom));
          bus_stop();
        end
      endcase
    end

    wait_clk(8);
    chk("writes_drained", 32'(wq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
